// File: rtl/i2s_rx_deserializer.sv
// I2S slave receiver: synchronizes BCLK/LRCLK/SDATA into ACLK, assembles
// {left, right} sample pairs and queues them in a first-word-fall-through FIFO.
module i2s_rx_deserializer #(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 3
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 EN,
  input  logic                 BCLK_I,
  input  logic                 LRCLK_I,
  input  logic                 SDATA_I,
  output logic [2*WIDTH-1:0]   M_TDATA,
  output logic                 M_TVALID,
  input  logic                 M_TREADY,
  output logic [ADDR_W:0]      FIFO_LEVEL,
  output logic                 OVERFLOW,
  input  logic                 OVF_CLR
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_ALIGN = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  logic [1:0]           bclk_sync;
  logic [1:0]           lrclk_sync;
  logic [1:0]           sdata_sync;
  logic                 bclk_prev;
  logic                 lr_q;
  logic                 lr_qq;
  logic [1:0]           state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [WIDTH-1:0]     shift_reg;
  logic [WIDTH-1:0]     left_hold;
  logic                 push_req;
  logic [2*WIDTH-1:0]   push_data;
  logic [2*WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]    rd_ptr;

  logic                 bclk_rise;
  logic                 lr_change;
  logic                 sdata_bit;
  logic [WIDTH-1:0]     msb_word;
  logic [WIDTH-1:0]     bit_mask;
  logic                 fifo_full;
  logic                 do_pop;
  logic                 do_push;
  logic                 drop;

  assign bclk_rise = bclk_sync[1] & ~bclk_prev;
  assign lr_change = lr_q ^ lr_qq;
  assign sdata_bit = sdata_sync[1];
  assign msb_word  = {sdata_bit, {(WIDTH-1){1'b0}}};
  // One-hot pointer to the next bit position; words shorter than WIDTH keep zeros below.
  assign bit_mask  = {1'b1, {(WIDTH-1){1'b0}}} >> bit_cnt;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      sdata_sync <= '0;
      bclk_prev  <= 1'b0;
      lr_q       <= 1'b0;
      lr_qq      <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[0], BCLK_I};
      lrclk_sync <= {lrclk_sync[0], LRCLK_I};
      sdata_sync <= {sdata_sync[0], SDATA_I};
      bclk_prev  <= bclk_sync[1];
      if (bclk_rise) begin
        lr_q  <= lrclk_sync[1];
        lr_qq <= lr_q;
      end
    end
  end

  // A word select change seen on the previous rise marks this rise as the MSB of channel lr_q.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= ST_ALIGN;
      bit_cnt   <= '0;
      shift_reg <= '0;
      left_hold <= '0;
      push_req  <= 1'b0;
      push_data <= '0;
    end else begin
      push_req <= 1'b0;
      if (!EN) begin
        state     <= ST_ALIGN;
        bit_cnt   <= '0;
        shift_reg <= '0;
        left_hold <= '0;
      end else if (bclk_rise) begin
        case (state)
          ST_ALIGN: begin
            if (lr_change && !lr_q) begin
              shift_reg <= msb_word;
              bit_cnt   <= CNT_W'(1);
              state     <= ST_LEFT;
            end
          end
          ST_LEFT, ST_RIGHT: begin
            if (lr_change && (lr_q == (state == ST_LEFT))) begin
              if (state == ST_LEFT) begin
                left_hold <= shift_reg;
                state     <= ST_RIGHT;
              end else begin
                push_req  <= 1'b1;
                push_data <= {left_hold, shift_reg};
                state     <= ST_LEFT;
              end
              shift_reg <= msb_word;
              bit_cnt   <= CNT_W'(1);
            end else if (bit_cnt < CNT_W'(WIDTH)) begin
              if (sdata_bit) shift_reg <= shift_reg | bit_mask;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          default: state <= ST_ALIGN;
        endcase
      end
    end
  end

  assign fifo_full = (FIFO_LEVEL == (ADDR_W+1)'(DEPTH));
  assign do_pop    = M_TVALID & M_TREADY;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign do_push   = push_req & (~fifo_full | do_pop);
  assign drop      = push_req & fifo_full & ~do_pop;
  assign M_TVALID  = (FIFO_LEVEL != '0);
  assign M_TDATA   = mem[rd_ptr];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_LEVEL <= '0;
      OVERFLOW   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   FIFO_LEVEL <= FIFO_LEVEL + 1'b1;
        2'b01:   FIFO_LEVEL <= FIFO_LEVEL - 1'b1;
        default: FIFO_LEVEL <= FIFO_LEVEL;
      endcase
      if (drop)         OVERFLOW <= 1'b1;
      else if (OVF_CLR) OVERFLOW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for i2s_rx_deserializer: drives a codec-style I2S bit stream and
// compares the popped pairs against a frame-level model of kept sample bits.
module tb_i2s_rx_deserializer;

  localparam int WIDTH  = 24;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        EN;
  logic        BCLK_I;
  logic        LRCLK_I;
  logic        SDATA_I;
  logic [47:0] M_TDATA;
  logic        M_TVALID;
  logic        M_TREADY;
  logic [3:0]  FIFO_LEVEL;
  logic        OVERFLOW;
  logic        OVF_CLR;

  int total = 0;
  int bad   = 0;

  bit          lrq[$];
  bit          dq[$];
  logic [47:0] exp_q[$];
  event        tail_rise;

  always #5 ACLK = ~ACLK;

  i2s_rx_deserializer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .EN(EN),
    .BCLK_I(BCLK_I), .LRCLK_I(LRCLK_I), .SDATA_I(SDATA_I),
    .M_TDATA(M_TDATA), .M_TVALID(M_TVALID), .M_TREADY(M_TREADY),
    .FIFO_LEVEL(FIFO_LEVEL), .OVERFLOW(OVERFLOW), .OVF_CLR(OVF_CLR)
  );

  // Bits the receiver keeps from a slot-wide word: top 24 bits, zero-filled when short.
  function automatic logic [23:0] kept(input logic [31:0] w, input int slot);
    logic [31:0] t;
    if (slot >= 24) t = w >> (slot - 24);
    else            t = w << (24 - slot);
    return t[23:0];
  endfunction

  function automatic logic [31:0] rnd_word(input int slot);
    logic [31:0] w;
    w = $urandom;
    if (slot < 32) w = w & ((32'd1 << slot) - 32'd1);
    return w;
  endfunction

  task automatic add_slot(input bit ch, input logic [31:0] w, input int slot);
    for (int i = slot - 1; i >= 0; i--) begin
      lrq.push_back(ch);
      dq.push_back(w[i]);
    end
  endtask

  task automatic add_frame(input logic [31:0] l, input logic [31:0] r, input int slot);
    add_slot(1'b0, l, slot);
    add_slot(1'b1, r, slot);
    exp_q.push_back({kept(l, slot), kept(r, slot)});
  endtask

  // Word select leads data by one bit clock, as a standard I2S transmitter does.
  task automatic play(input int en_at);
    @(negedge ACLK);
    for (int n = 0; n < lrq.size(); n++) begin
      BCLK_I  = 1'b0;
      LRCLK_I = lrq[n];
      SDATA_I = (n > 0) ? dq[n-1] : 1'b0;
      if (n == en_at) EN = 1'b1;
      #40;
      BCLK_I = 1'b1;
      if (n == lrq.size() - 1) ->tail_rise;
      #40;
    end
    lrq.delete();
    dq.delete();
  endtask

  task automatic start_burst(input int slot);
    @(negedge ACLK);
    EN = 1'b0;
    repeat (3) @(negedge ACLK);
    EN = 1'b1;
    add_slot(1'b1, rnd_word(slot), slot);
  endtask

  task automatic end_burst();
    add_slot(1'b0, rnd_word(2), 2);
    play(-1);
  endtask

  task automatic pop_one(output logic [47:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge ACLK);
      if (M_TVALID) begin
        d        = M_TDATA;
        ok       = 1'b1;
        M_TREADY = 1'b1;
        @(negedge ACLK);
        M_TREADY = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; EN = 1'b0; BCLK_I = 1'b0; LRCLK_I = 1'b0; SDATA_I = 1'b0;
    M_TREADY = 1'b0; OVF_CLR = 1'b0;
    repeat (3) @(negedge ACLK);
    total++; if (M_TVALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", M_TVALID); end
    total++; if (FIFO_LEVEL !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", FIFO_LEVEL); end
    total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", OVERFLOW); end
    total++; if (M_TDATA !== 48'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", M_TDATA); end
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
  endtask

  task automatic test_single_pair();
    logic [47:0] got, exp;
    bit          ok;
    start_burst(32);
    add_frame(32'hA5A5A500 | (32'($urandom) & 32'hFF), 32'h5A5A5A00 | (32'($urandom) & 32'hFF), 32);
    end_burst();
    for (int i = 0; i < 2 && !M_TVALID; i++) @(negedge ACLK);
    total++; if (M_TVALID !== 1'b1) begin bad++; $display("FAIL pair_valid_latency got=%b exp=1", M_TVALID); end
    total++; if (M_TDATA !== 48'hA5A5A5_5A5A5A) begin bad++; $display("FAIL pair_fixed got=%h exp=a5a5a55a5a5a", M_TDATA); end
    start_burst(32);
    for (int k = 0; k < 3; k++) add_frame(rnd_word(32), rnd_word(32), 32);
    end_burst();
    while (exp_q.size() > 0) begin
      pop_one(got, ok);
      exp = exp_q.pop_front();
      total++; if (!ok || got !== exp) begin bad++; $display("FAIL pair32 got=%h ok=%0d exp=%h", got, ok, exp); end
    end
  endtask

  task automatic test_short_word();
    logic [47:0] got, exp;
    bit          ok;
    start_burst(16);
    add_frame(32'h8001, 32'h7FFF, 16);
    end_burst();
    pop_one(got, ok);
    void'(exp_q.pop_front());
    total++; if (!ok || got !== 48'h800100_7FFF00) begin bad++; $display("FAIL short_fixed got=%h ok=%0d exp=8001007fff00", got, ok); end
    for (int b = 0; b < 2; b++) begin
      int slot;
      slot = (b == 0) ? 16 : 24;
      start_burst(slot);
      for (int k = 0; k < 2; k++) add_frame(rnd_word(slot), rnd_word(slot), slot);
      end_burst();
    end
    while (exp_q.size() > 0) begin
      pop_one(got, ok);
      exp = exp_q.pop_front();
      total++; if (!ok || got !== exp) begin bad++; $display("FAIL short_rand got=%h ok=%0d exp=%h", got, ok, exp); end
    end
  endtask

  task automatic test_overflow();
    logic [47:0] got, exp;
    bit          ok;
    M_TREADY = 1'b0;
    start_burst(16);
    for (int k = 0; k < 10; k++) add_frame(rnd_word(16), rnd_word(16), 16);
    end_burst();
    repeat (8) @(negedge ACLK);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    total++; if (FIFO_LEVEL !== 4'd8) begin bad++; $display("FAIL ovf_level got=%0d exp=8", FIFO_LEVEL); end
    total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", OVERFLOW); end
    while (exp_q.size() > 0) begin
      pop_one(got, ok);
      exp = exp_q.pop_front();
      total++; if (!ok || got !== exp) begin bad++; $display("FAIL ovf_order got=%h ok=%0d exp=%h", got, ok, exp); end
    end
    total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", OVERFLOW); end
    @(negedge ACLK); OVF_CLR = 1'b1;
    @(negedge ACLK); OVF_CLR = 1'b0;
    total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", OVERFLOW); end
    total++; if (FIFO_LEVEL !== 4'd0) begin bad++; $display("FAIL ovf_drained got=%0d exp=0", FIFO_LEVEL); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] got, exp, head, new_pair;
    logic [31:0] l, r;
    logic [3:0]  lvl0, lvl1;
    logic        ov0;
    bit          ok;
    int          hits;
    hits = 0;
    M_TREADY = 1'b0;
    for (int d = 0; d < 7; d++) begin
      while (exp_q.size() < DEPTH) begin
        start_burst(16);
        add_frame(rnd_word(16), rnd_word(16), 16);
        end_burst();
      end
      repeat (4) @(negedge ACLK);
      OVF_CLR = 1'b1;
      @(negedge ACLK);
      OVF_CLR = 1'b0;
      start_burst(16);
      l = rnd_word(16);
      r = rnd_word(16);
      add_slot(1'b0, l, 16);
      add_slot(1'b1, r, 16);
      add_slot(1'b0, rnd_word(2), 2);
      new_pair = {kept(l, 16), kept(r, 16)};
      fork
        play(-1);
        begin
          @(tail_rise);
          repeat (d) @(posedge ACLK);
          @(negedge ACLK);
          lvl0 = FIFO_LEVEL; ov0 = OVERFLOW; head = M_TDATA;
          M_TREADY = 1'b1;
          @(negedge ACLK);
          M_TREADY = 1'b0;
          lvl1 = FIFO_LEVEL;
        end
      join
      repeat (8) @(negedge ACLK);
      exp = exp_q.pop_front();
      total++; if (head !== exp) begin bad++; $display("FAIL b2b_head d=%0d got=%h exp=%h", d, head, exp); end
      if (!ov0 && lvl0 == 4'd8) begin
        exp_q.push_back(new_pair);
        if (lvl1 == 4'd8) hits++;
        total++; if (OVERFLOW !== 1'b0 || FIFO_LEVEL !== 4'd8) begin
          bad++; $display("FAIL b2b_accept d=%0d ovf=%b level=%0d exp ovf=0 level=8", d, OVERFLOW, FIFO_LEVEL);
        end
      end else begin
        total++; if (ov0 !== 1'b1 || lvl0 !== 4'd8 || OVERFLOW !== 1'b1 || FIFO_LEVEL !== 4'd7) begin
          bad++; $display("FAIL b2b_drop d=%0d ovf=%b level=%0d exp ovf=1 level=7", d, OVERFLOW, FIFO_LEVEL);
        end
      end
    end
    total++; if (hits == 0) begin bad++; $display("FAIL b2b_coincident got=%0d exp>=1", hits); end
    while (exp_q.size() > 0) begin
      pop_one(got, ok);
      exp = exp_q.pop_front();
      total++; if (!ok || got !== exp) begin bad++; $display("FAIL b2b_order got=%h ok=%0d exp=%h", got, ok, exp); end
    end
    @(negedge ACLK); OVF_CLR = 1'b1;
    @(negedge ACLK); OVF_CLR = 1'b0;
  endtask

  task automatic test_en_midframe();
    logic [47:0] got, exp;
    bit          ok;
    @(negedge ACLK);
    EN = 1'b0;
    add_slot(1'b1, rnd_word(24), 24);
    add_slot(1'b0, rnd_word(24), 24);
    add_slot(1'b1, rnd_word(24), 24);
    for (int k = 0; k < 2; k++) add_frame(rnd_word(24), rnd_word(24), 24);
    add_slot(1'b0, rnd_word(2), 2);
    play(60);
    repeat (8) @(negedge ACLK);
    total++; if (FIFO_LEVEL !== 4'd2) begin bad++; $display("FAIL en_level got=%0d exp=2", FIFO_LEVEL); end
    while (exp_q.size() > 0) begin
      pop_one(got, ok);
      exp = exp_q.pop_front();
      total++; if (!ok || got !== exp) begin bad++; $display("FAIL en_pair got=%h ok=%0d exp=%h", got, ok, exp); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [47:0] got, exp;
    bit          ok;
    start_burst(24);
    for (int k = 0; k < 3; k++) add_frame(rnd_word(24), rnd_word(24), 24);
    end_burst();
    repeat (6) @(negedge ACLK);
    total++; if (FIFO_LEVEL !== 4'd3) begin bad++; $display("FAIL rst_prequeue got=%0d exp=3", FIFO_LEVEL); end
    exp_q.delete();
    start_burst(24);
    add_slot(1'b0, rnd_word(24), 24);
    add_slot(1'b1, rnd_word(24), 24);
    fork
      play(-1);
      begin
        #(36 * 80);
        @(negedge ACLK);
        ARESETN = 1'b0;
        @(negedge ACLK);
        total++; if (M_TVALID !== 1'b0 || FIFO_LEVEL !== 4'd0 || OVERFLOW !== 1'b0 || M_TDATA !== 48'd0) begin
          bad++; $display("FAIL rst_mid valid=%b level=%0d ovf=%b data=%h exp 0/0/0/0", M_TVALID, FIFO_LEVEL, OVERFLOW, M_TDATA);
        end
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
      end
    join
    start_burst(24);
    add_frame(rnd_word(24), rnd_word(24), 24);
    end_burst();
    pop_one(got, ok);
    exp = exp_q.pop_front();
    total++; if (!ok || got !== exp) begin bad++; $display("FAIL rst_next got=%h ok=%0d exp=%h", got, ok, exp); end
    repeat (4) @(negedge ACLK);
    total++; if (FIFO_LEVEL !== 4'd0) begin bad++; $display("FAIL rst_final_level got=%0d exp=0", FIFO_LEVEL); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_pair();
    test_short_word();
    test_overflow();
    test_back_to_back();
    test_en_midframe();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
